acq_readout_sequencer: RTL and testbench
========================================

ACQ_READOUT_SEQUENCER -- requirements
Module: acq_readout_sequencer

Interface
REQ-001 Parameter: TIMEOUT, default 16'd40000, max clk cycles a channel readout may take before it is abandoned.
REQ-002 The block SHALL have a single clock domain; reset is asynchronous and active-high.
REQ-003 Ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  40 MHz TTC clock
- reset  in  1  async active-high reset
- chan_en  in  5  channels enabled for readout
- clear_errors  in  1  sync clear of sticky error flags
- evt_fifo_valid  in  1  acquisition event FIFO word available (first-word-fall-through)
- evt_fifo_data  in  32  {3'd0, trig_type[4:0], trig_num[23:0]}
- evt_fifo_ready  out  1  FIFO pop
- hdr_valid  out  1  event header valid
- hdr_data  out  32  {num_err_this_event, 2'b00, trig_type[4:0], trig_num[23:0]}
- hdr_ready  in  1  header consumer ready
- chan_rd_req  out  5  one-hot readout request to channel FPGA
- chan_rd_done  in  5  per-channel readout complete pulse
- readout_done  out  1  one-cycle pulse; event fully read out
- trig_num_err  out  1  sticky: trigger number out of sequence
- chan_timeout  out  5  sticky per-channel timeout flags
- event_count  out  24  completed events
- state  out  5  one-hot FSM state

Function
REQ-004 FSM SHALL be one-hot, states IDLE, HEADER, SCAN, READ, DONE; exactly one bit set at all times.
REQ-005 evt_fifo_ready SHALL be high iff state is IDLE; a word is accepted when evt_fifo_valid & evt_fifo_ready.
REQ-006 On accept: latch trig_type=data[28:24], trig_num=data[23:0], mask=chan_en; go HEADER next cycle.
REQ-007 On accept: if trig_num != expected_num, set trig_num_err and latch num_err_this_event=1, else 0; expected_num <= trig_num+1 modulo 2^24 (24'hFFFFFF wraps to 0).
REQ-008 HEADER: hdr_valid=1 with hdr_data stable; on hdr_valid & hdr_ready go SCAN with idx=0; otherwise hold.
REQ-009 SCAN: idx==5 -> DONE; mask[idx]=1 -> READ; mask[idx]=0 -> idx+1, stay SCAN (one cycle per skipped channel).
REQ-010 READ: chan_rd_req = 1<<idx, all other bits 0; timeout counter starts at 0 on entry, increments each READ cycle.
REQ-011 READ: chan_rd_done[idx]=1 -> idx+1, go SCAN; done bits of other channels SHALL be ignored.
REQ-012 READ: counter reaching TIMEOUT-1 without done -> set chan_timeout[idx], idx+1, go SCAN; done in that same cycle takes priority (no timeout flagged).
REQ-013 DONE: readout_done=1 for exactly that cycle, event_count+1 (wraps at 2^24), go IDLE.
REQ-014 chan_en changes after accept SHALL NOT affect the current event; mask=0 events pass HEADER, SCAN x6, DONE.
REQ-015 clear_errors clears trig_num_err and chan_timeout; an error set in the same cycle SHALL win.
REQ-016 hdr_valid, chan_rd_req, readout_done, evt_fifo_ready SHALL be decoded from the registered state only (no input-to-output combinational path).

Reset
REQ-017 Reset SHALL force state=IDLE, idx=0, expected_num=24'd1, event_count=0, trig_num_err=0, chan_timeout=0, latched type/num/mask=0, timeout counter=0.
REQ-018 During reset: evt_fifo_ready=1, hdr_valid=0, chan_rd_req=0, readout_done=0; reset mid-event abandons the event with no readout_done.

Verification
REQ-019 Word 0x00_0_000001 (type 0, num 1) accepted cycle 0, mask 5'b00001, hdr_ready=1, chan_rd_done[0] pulsed on first READ cycle -> hdr_valid cycle 1, chan_rd_req=5'b00001 cycle 3, readout_done cycle 9, event_count=1, trig_num_err=0.
REQ-020 Mask 5'b10101, dones after 3 cycles each -> chan_rd_req sequence 00001, 00100, 10000 only; one readout_done.
REQ-021 Trigger nums 1, 2, 4 -> trig_num_err set on third event, hdr_data[31]=1 for it only; num 24'hFFFFFF followed by 0 -> no error.
REQ-022 Channel 2 never done, TIMEOUT=16 -> chan_timeout=5'b00100 after 16 READ cycles, sequencing continues, readout_done asserted; clear_errors clears it.
REQ-023 hdr_ready held low 10 cycles -> hdr_valid/hdr_data held stable, evt_fifo_ready low, no chan_rd_req.
REQ-024 Reset asserted during READ -> state=IDLE and chan_rd_req=0 immediately, no readout_done, event_count unchanged.

Source files
------------

// File: rtl/acq_readout_sequencer.sv
// Event readout sequencer: pops one trigger word, presents an event header, then
// requests each enabled channel in turn, abandoning a channel that exceeds TIMEOUT.
module acq_readout_sequencer #(
    parameter logic [15:0] TIMEOUT = 16'd40000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  chan_en,
    input  logic        clear_errors,
    input  logic        evt_fifo_valid,
    input  logic [31:0] evt_fifo_data,
    output logic        evt_fifo_ready,
    output logic        hdr_valid,
    output logic [31:0] hdr_data,
    input  logic        hdr_ready,
    output logic [4:0]  chan_rd_req,
    input  logic [4:0]  chan_rd_done,
    output logic        readout_done,
    output logic        trig_num_err,
    output logic [4:0]  chan_timeout,
    output logic [23:0] event_count,
    output logic [4:0]  state
);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        HEADER = 5'b00010,
        SCAN   = 5'b00100,
        READ   = 5'b01000,
        DONE   = 5'b10000
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;

    state_t      fsm;
    logic [2:0]  idx;
    logic [23:0] expected_num;
    logic [23:0] trig_num_q;
    logic [4:0]  trig_type_q;
    logic [4:0]  mask;
    logic        num_err_q;
    logic [15:0] tmo_cnt;

    // Handshake outputs decode the registered state only, so no input reaches them combinationally.
    assign state          = fsm;
    assign evt_fifo_ready = (fsm == IDLE);
    assign hdr_valid      = (fsm == HEADER);
    assign readout_done   = (fsm == DONE);
    assign chan_rd_req    = (fsm == READ) ? (5'b00001 << idx) : 5'b00000;
    assign hdr_data       = {num_err_q, 2'b00, trig_type_q, trig_num_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm          <= IDLE;
            idx          <= 3'd0;
            expected_num <= 24'd1;
            trig_num_q   <= 24'd0;
            trig_type_q  <= 5'd0;
            mask         <= 5'd0;
            num_err_q    <= 1'b0;
            tmo_cnt      <= 16'd0;
            event_count  <= 24'd0;
            trig_num_err <= 1'b0;
            chan_timeout <= 5'd0;
        end else begin
            // NOTE: the clear is written first so a flag set later in this block in the same cycle overrides it.
            if (clear_errors) begin
                trig_num_err <= 1'b0;
                chan_timeout <= 5'd0;
            end

            case (fsm)
                IDLE: begin
                    if (evt_fifo_valid) begin
                        trig_type_q  <= evt_fifo_data[28:24];
                        trig_num_q   <= evt_fifo_data[23:0];
                        mask         <= chan_en;
                        num_err_q    <= (evt_fifo_data[23:0] != expected_num);
                        expected_num <= evt_fifo_data[23:0] + 24'd1;
                        if (evt_fifo_data[23:0] != expected_num) begin
                            trig_num_err <= 1'b1;
                        end
                        fsm <= HEADER;
                    end
                end
                HEADER: begin
                    if (hdr_ready) begin
                        idx <= 3'd0;
                        fsm <= SCAN;
                    end
                end
                SCAN: begin
                    if (idx == 3'd5) begin
                        fsm <= DONE;
                    end else if (mask[idx]) begin
                        tmo_cnt <= 16'd0;
                        fsm     <= READ;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                READ: begin
                    // A done arriving on the final allowed cycle beats the timeout.
                    if (chan_rd_done[idx]) begin
                        idx <= idx + 3'd1;
                        fsm <= SCAN;
                    end else if (tmo_cnt == TIMEOUT_LAST) begin
                        chan_timeout[idx] <= 1'b1;
                        idx <= idx + 3'd1;
                        fsm <= SCAN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                DONE: begin
                    event_count <= event_count + 24'd1;
                    fsm         <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acq_readout_sequencer.sv
// Self-checking bench for acq_readout_sequencer: directed vector table, reset-abort
// sequence, and randomized events checked against a cycle-count reference model.
module tb_acq_readout_sequencer;

    localparam int TMO = 16;

    typedef struct packed {
        logic [4:0]       ttype;
        logic [23:0]      num;
        logic [4:0]       mask;
        logic [4:0][7:0]  dly;    // READ cycles before done per channel; >= TMO means never
        logic [7:0]       stall;  // HEADER cycles with hdr_ready low
        logic             clr;    // clear_errors asserted on the accept cycle
    } evt_t;

    typedef struct packed {
        logic [31:0] hdr;
        logic [24:0] reqs;
        logic [3:0]  nreq;
        logic [15:0] cyc;
        logic        ok;
    } obs_t;

    typedef struct packed {
        evt_t        e;
        logic [15:0] exp_cyc;
        logic        exp_err;
        logic        exp_terr;
        logic [4:0]  exp_tmo;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  chan_en;
    logic        clear_errors;
    logic        evt_fifo_valid;
    logic [31:0] evt_fifo_data;
    logic        evt_fifo_ready;
    logic        hdr_valid;
    logic [31:0] hdr_data;
    logic        hdr_ready;
    logic [4:0]  chan_rd_req;
    logic [4:0]  chan_rd_done;
    logic        readout_done;
    logic        trig_num_err;
    logic [4:0]  chan_timeout;
    logic [23:0] event_count;
    logic [4:0]  state;

    acq_readout_sequencer #(.TIMEOUT(16'd16)) dut (
        .clk(clk), .reset(reset), .chan_en(chan_en), .clear_errors(clear_errors),
        .evt_fifo_valid(evt_fifo_valid), .evt_fifo_data(evt_fifo_data),
        .evt_fifo_ready(evt_fifo_ready), .hdr_valid(hdr_valid), .hdr_data(hdr_data),
        .hdr_ready(hdr_ready), .chan_rd_req(chan_rd_req), .chan_rd_done(chan_rd_done),
        .readout_done(readout_done), .trig_num_err(trig_num_err),
        .chan_timeout(chan_timeout), .event_count(event_count), .state(state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] m_exp;
    logic        m_terr;
    logic [4:0]  m_tmo;
    logic [23:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic evt_t mk(input logic [4:0] ttype, input logic [23:0] num,
                                input logic [4:0] mask, input logic [7:0] dly,
                                input logic [7:0] stall, input logic clr);
        evt_t e;
        e.ttype = ttype; e.num = num; e.mask = mask;
        e.dly = {5{dly}}; e.stall = stall; e.clr = clr;
        return e;
    endfunction

    // Timeline: accept at 0, header from 1, first SCAN at 2+stall; one SCAN cycle per
    // channel slot plus its READ time, one final SCAN, then the DONE cycle.
    function automatic void model_event(input evt_t e, output logic [15:0] cyc,
                                        output logic [24:0] reqs, output logic [3:0] nreq,
                                        output logic [4:0] tmo);
        int acc;
        int k;
        acc = 2 + int'(e.stall);
        reqs = '0; k = 0; tmo = '0;
        for (int c = 0; c < 5; c++) begin
            acc++;
            if (e.mask[c]) begin
                reqs[k*5 +: 5] = 5'b00001 << c;
                k++;
                if (int'(e.dly[c]) < TMO) acc += int'(e.dly[c]) + 1;
                else begin acc += TMO; tmo[c] = 1'b1; end
            end
        end
        cyc  = 16'(acc + 1);
        nreq = 4'(k);
    endfunction

    // Drives one event from an IDLE cycle and records what the DUT did.
    task automatic run_event(input evt_t e, output obs_t o);
        int cyc, r, ch, hdr_cnt;
        logic [4:0] prev_req;
        bit done;
        o = '0; o.ok = 1'b1;
        if (!evt_fifo_ready) o.ok = 1'b0;
        evt_fifo_valid = 1'b1;
        evt_fifo_data  = {3'd0, e.ttype, e.num};
        chan_en        = e.mask;
        clear_errors   = e.clr;
        hdr_ready      = 1'b0;
        chan_rd_done   = 5'd0;
        tick();
        evt_fifo_valid = 1'b0;
        evt_fifo_data  = $urandom;
        clear_errors   = 1'b0;
        chan_en        = 5'($urandom);
        cyc = 1; r = 0; hdr_cnt = 0; prev_req = 5'd0; done = 0;
        while (!done && cyc < 600) begin
            if (!$onehot(state) || evt_fifo_ready) o.ok = 1'b0;
            hdr_ready    = 1'b0;
            chan_rd_done = 5'($urandom);
            if (hdr_valid) begin
                if (hdr_cnt == 0) o.hdr = hdr_data;
                else if (hdr_data != o.hdr) o.ok = 1'b0;
                if (chan_rd_req != 5'd0) o.ok = 1'b0;
                hdr_ready = (hdr_cnt >= int'(e.stall));
                hdr_cnt++;
            end
            if (chan_rd_req != 5'd0) begin
                if (!$onehot(chan_rd_req)) o.ok = 1'b0;
                if (prev_req == 5'd0) begin
                    if (o.nreq < 4'd5) o.reqs[int'(o.nreq)*5 +: 5] = chan_rd_req;
                    if (o.nreq < 4'd15) o.nreq++;
                    r = 0;
                end else begin
                    r++;
                end
                ch = 0;
                for (int b = 0; b < 5; b++) if (chan_rd_req[b]) ch = b;
                chan_rd_done[ch] = (r == int'(e.dly[ch]));
            end
            prev_req = chan_rd_req;
            if (readout_done) begin
                done  = 1;
                o.cyc = 16'(cyc);
            end else begin
                tick();
                cyc++;
            end
        end
        chan_rd_done = 5'd0;
        if (done) begin
            tick();
            if (readout_done || !evt_fifo_ready) o.ok = 1'b0;
        end
    endtask

    task automatic verify(input obs_t o, input logic [31:0] exp_hdr, input logic [15:0] exp_cyc,
                          input logic [24:0] exp_reqs, input logic [3:0] exp_nreq,
                          input logic exp_terr, input logic [4:0] exp_tmo, input logic [23:0] exp_cnt);
        check("hdr_data",     o.hdr,        exp_hdr);
        check("done_cycle",   32'(o.cyc),   32'(exp_cyc));
        check("req_sequence", 32'(o.reqs),  32'(exp_reqs));
        check("req_count",    32'(o.nreq),  32'(exp_nreq));
        check("protocol",     32'(o.ok),    32'd1);
        check("trig_num_err", 32'(trig_num_err), 32'(exp_terr));
        check("chan_timeout", 32'(chan_timeout), 32'(exp_tmo));
        check("event_count",  32'(event_count),  32'(exp_cnt));
    endtask

    // Update the reference flags for an accepted event and return its header error bit.
    function automatic logic model_accept(input evt_t e, input logic [4:0] tmo);
        logic err;
        err   = (e.num != m_exp);
        m_exp = e.num + 24'd1;
        if (e.clr) begin m_terr = 1'b0; m_tmo = 5'd0; end
        if (err) m_terr = 1'b1;
        m_tmo = m_tmo | tmo;
        m_cnt = m_cnt + 24'd1;
        return err;
    endfunction

    vec_t vecs [8];

    initial begin
        obs_t        o;
        evt_t        e;
        logic [15:0] mc;
        logic [24:0] mr;
        logic [3:0]  mn;
        logic [4:0]  mt;
        logic        err;
        bit          seen_done;
        int          w;

        vecs[0] = '{mk(5'd0,  24'd1,       5'b00001, 8'd0,   8'd0,  1'b0), 16'd9,  1'b0, 1'b0, 5'b00000};
        vecs[1] = '{mk(5'd3,  24'd2,       5'b10101, 8'd3,   8'd0,  1'b0), 16'd20, 1'b0, 1'b0, 5'b00000};
        vecs[2] = '{mk(5'd17, 24'd4,       5'b00000, 8'd0,   8'd0,  1'b0), 16'd8,  1'b1, 1'b1, 5'b00000};
        vecs[3] = '{mk(5'd2,  24'd5,       5'b00010, 8'd1,   8'd10, 1'b0), 16'd20, 1'b0, 1'b1, 5'b00000};
        vecs[4] = '{mk(5'd1,  24'd6,       5'b00100, 8'd255, 8'd0,  1'b0), 16'd24, 1'b0, 1'b1, 5'b00100};
        vecs[5] = '{mk(5'd31, 24'hFFFFFF,  5'b00000, 8'd0,   8'd0,  1'b1), 16'd8,  1'b1, 1'b1, 5'b00000};
        vecs[6] = '{mk(5'd4,  24'd0,       5'b00000, 8'd0,   8'd0,  1'b0), 16'd8,  1'b0, 1'b1, 5'b00000};
        vecs[7] = '{mk(5'd0,  24'd1,       5'b00001, 8'd15,  8'd0,  1'b0), 16'd24, 1'b0, 1'b1, 5'b00000};

        reset = 1'b1; chan_en = 5'd0; clear_errors = 1'b0; evt_fifo_valid = 1'b0;
        evt_fifo_data = 32'd0; hdr_ready = 1'b0; chan_rd_done = 5'd0;
        tick(); tick();
        check("rst_fifo_ready", 32'(evt_fifo_ready), 32'd1);
        check("rst_hdr_valid",  32'(hdr_valid),      32'd0);
        check("rst_rd_req",     32'(chan_rd_req),    32'd0);
        check("rst_done",       32'(readout_done),   32'd0);
        check("rst_state",      32'(state),          32'b00001);
        check("rst_flags",      {trig_num_err, chan_timeout, event_count}, 32'd0);
        check("rst_hdr_data",   hdr_data,            32'd0);
        reset = 1'b0;
        tick();

        // Reset in the middle of a READ abandons the event.
        evt_fifo_valid = 1'b1; evt_fifo_data = 32'h0000_0001; chan_en = 5'b00001; hdr_ready = 1'b1;
        tick();
        evt_fifo_valid = 1'b0;
        w = 0;
        while (chan_rd_req == 5'd0 && w < 20) begin tick(); w++; end
        check("abort_reach_read", 32'(chan_rd_req), 32'b00001);
        #3 reset = 1'b1;
        #1;
        check("abort_state",      32'(state),          32'b00001);
        check("abort_rd_req",     32'(chan_rd_req),    32'd0);
        check("abort_fifo_ready", 32'(evt_fifo_ready), 32'd1);
        seen_done = 0;
        repeat (3) begin tick(); if (readout_done) seen_done = 1; end
        reset = 1'b0;
        repeat (12) begin tick(); if (readout_done) seen_done = 1; end
        check("abort_no_done",     32'(seen_done),   32'd0);
        check("abort_event_count", 32'(event_count), 32'd0);
        hdr_ready = 1'b0;

        m_exp = 24'd1; m_terr = 1'b0; m_tmo = 5'd0; m_cnt = 24'd0;

        for (int i = 0; i < 8; i++) begin
            e = vecs[i].e;
            model_event(e, mc, mr, mn, mt);
            err = model_accept(e, mt);
            run_event(e, o);
            verify(o, {vecs[i].exp_err, 2'b00, e.ttype, e.num}, vecs[i].exp_cyc, mr, mn,
                   vecs[i].exp_terr, vecs[i].exp_tmo, 24'(i + 1));
        end

        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        check("clear_trig_err", 32'(trig_num_err), 32'd0);
        check("clear_timeout",  32'(chan_timeout), 32'd0);
        m_terr = 1'b0; m_tmo = 5'd0;

        for (int i = 0; i < 40; i++) begin
            e.ttype = 5'($urandom);
            e.num   = ($urandom_range(0, 3) == 0) ? 24'($urandom) : m_exp;
            e.mask  = 5'($urandom);
            for (int c = 0; c < 5; c++) begin
                w = int'($urandom_range(0, 20));
                e.dly[c] = (w > 17) ? 8'd255 : 8'(w);
            end
            e.stall = 8'($urandom_range(0, 3));
            e.clr   = ($urandom_range(0, 7) == 0);
            model_event(e, mc, mr, mn, mt);
            err = model_accept(e, mt);
            run_event(e, o);
            verify(o, {err, 2'b00, e.ttype, e.num}, mc, mr, mn, m_terr, m_tmo, m_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
